// File: rtl/mcpu_mem_responder.sv
`timescale 1ns/1ps
// Single-port word memory behind a req/ready handshake with a fixed number of
// wait states. Requests are latched on accept; the response strobe lasts one cycle.
module mcpu_mem_responder #(
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               we_q, we_d;
   logic               err_q, err_d;
   logic               mem_we;
   logic [31:0]        mem [2**DEPTH_LOG2];

   function automatic logic addr_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
   endfunction

   assign err_q = addr_err(addr_q);
   assign err_d = addr_err(addr_d);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d  = addr;
               wdata_d = wdata;
               we_d    = we;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = S_RESP;
         end
         S_RESP: begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Commit on the edge entering RESP using next-latched values, so the
   // zero-wait path (IDLE->RESP) writes the incoming request directly.
   assign mem_we = (state_q != S_RESP) && (state_d == S_RESP) && we_d && !err_d && !reset;

   always_ff @(posedge clk) begin
      if (mem_we) mem[addr_d[DEPTH_LOG2+1:2]] <= wdata_d;
   end

   always_comb begin
      ready = 1'b0;
      err   = 1'b0;
      rdata = 32'd0;
      busy  = (state_q != S_IDLE);
      if (state_q == S_RESP) begin
         ready = 1'b1;
         err   = err_q;
         if (!we_q && !err_q) rdata = mem[addr_q[DEPTH_LOG2+1:2]];
      end
   end

endmodule

// File: tb/tb_mcpu_mem_responder.sv
`timescale 1ns/1ps
// Directed bench: one DUT with two wait states, one with none; expected
// responses are queued on accept and checked when ready strobes.
module tb_mcpu_mem_responder;

   logic        clk, reset;
   logic        req2, we2, ready2, err2, busy2;
   logic [31:0] addr2, wdata2, rdata2;
   logic        req0, we0, ready0, err0, busy0;
   logic [31:0] addr0, wdata0, rdata0;

   int nchk  = 0;
   int nfail = 0;

   typedef struct {
      logic [31:0] rd;
      logic        er;
   } exp_t;
   exp_t        sb[$];
   logic [31:0] mdl2 [int];
   logic [31:0] mdl0 [int];

   mcpu_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u2 (
      .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
      .ready(ready2), .rdata(rdata2), .err(err2), .busy(busy2));

   mcpu_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
      .ready(ready0), .rdata(rdata0), .err(err0), .busy(busy0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction on the selected DUT with latency and busy checks.
   task automatic txn(input bit d0, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input string tag);
      exp_t e;
      int   n;
      int   idx;
      bit   rdy;
      idx  = int'(a[9:2]);
      e.er = (a[1:0] != 2'b00) || ((a >> 10) != 32'd0);
      e.rd = 32'd0;
      if (!w && !e.er) e.rd = d0 ? mdl0[idx] : mdl2[idx];
      if (w && !e.er) begin
         if (d0) mdl0[idx] = d; else mdl2[idx] = d;
      end
      @(negedge clk);
      if (d0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
      else    begin req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d; end
      @(posedge clk);
      sb.push_back(e);
      #1;
      req0 = 1'b0; req2 = 1'b0;
      n = 0;
      rdy = 1'b0;
      while (!rdy && n < 20) begin
         @(negedge clk);
         n++;
         rdy = d0 ? ready0 : ready2;
         chk({tag, " busy"}, d0 ? busy0 : busy2, 1);
      end
      chk({tag, " latency"}, n, d0 ? 1 : 3);
      if (rdy && sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, " rdata"}, d0 ? rdata0 : rdata2, e.rd);
         chk({tag, " err"}, d0 ? err0 : err2, e.er);
      end else sb.delete();
      @(negedge clk);
      chk({tag, " idle ready"}, d0 ? ready0 : ready2, 0);
      chk({tag, " idle busy"}, d0 ? busy0 : busy2, 0);
      chk({tag, " idle rdata"}, d0 ? rdata0 : rdata2, 0);
   endtask

   initial begin
      exp_t e;
      reset = 1'b1;
      req2 = 0; we2 = 0; addr2 = 0; wdata2 = 0;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      #12;
      chk("rst ready", ready2, 0);
      chk("rst busy", busy2, 0);
      chk("rst err", err2, 0);
      chk("rst rdata", rdata2, 0);
      chk("rst0 ready", ready0, 0);
      chk("rst0 busy", busy0, 0);
      @(negedge clk);
      reset = 1'b0;

      txn(0, 1, 32'h10, 32'hDEADBEEF, "wr10");
      txn(0, 0, 32'h10, 32'h0, "rd10");
      txn(0, 1, 32'h13, 32'h1, "wr13 misaligned");
      txn(0, 0, 32'h10, 32'h0, "rd10 after err");
      txn(0, 0, 32'h400, 32'h0, "rd400 range");
      txn(0, 1, 32'h24, 32'h0BADF00D, "wr24");
      txn(0, 0, 32'h24, 32'h0, "rd24");

      // Reset during WAIT must abort the write to 0x20
      txn(0, 1, 32'h20, 32'hA5A5A5A5, "wr20 prior");
      @(negedge clk);
      req2 = 1'b1; we2 = 1'b1; addr2 = 32'h20; wdata2 = 32'h55;
      @(posedge clk);
      #1 req2 = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rstwait ready", ready2, 0);
         chk("rstwait busy", busy2, 0);
         chk("rstwait rdata", rdata2, 0);
      end
      reset = 1'b0;
      txn(0, 0, 32'h20, 32'h0, "rd20 after abort");

      // Back-to-back reads with req held high
      @(negedge clk);
      req2 = 1'b1; we2 = 1'b0; addr2 = 32'h10;
      e.rd = 32'hDEADBEEF; e.er = 1'b0;
      sb.push_back(e);
      sb.push_back(e);
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk($sformatf("b2b ready c%0d", k), ready2, (k % 4) == 3);
         chk($sformatf("b2b busy c%0d", k), busy2, (k % 4) != 0);
         if (ready2) begin
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("b2b rdata", rdata2, e.rd);
               chk("b2b err", err2, e.er);
            end else chk("b2b extra ready", 1, 0);
         end
      end
      req2 = 1'b0;
      chk("b2b pending", sb.size(), 0);
      sb.delete();

      // Zero wait states
      txn(1, 1, 32'h8, 32'h12345678, "z wr8");
      txn(1, 0, 32'h8, 32'h0, "z rd8");
      txn(1, 0, 32'h401, 32'h0, "z rd401");

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/mcpu_mem_responder.md
MCPU_MEM_RESPONDER -- requirements
Module: mcpu_mem_responder

Interface
REQ-001 SHALL have parameter: DEPTH_LOG2, 8, log2 of storage depth in 32-bit words.
REQ-002 SHALL have parameter: WAIT_CYCLES, 2, wait states inserted before response (legal 0..15).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: req  input  1  initiator request; held high by initiator until ready.
REQ-006 SHALL have port: we  input  1  1 = write, 0 = read; qualified by req.
REQ-007 SHALL have port: addr  input  32  byte address from initiator.
REQ-008 SHALL have port: wdata  input  32  write data; qualified by req and we.
REQ-009 SHALL have port: ready  output  1  one-cycle response strobe.
REQ-010 SHALL have port: rdata  output  32  read data; valid only while ready=1.
REQ-011 SHALL have port: err  output  1  access error; valid only while ready=1.
REQ-012 SHALL have port: busy  output  1  high in every state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: on a clk edge with req=1, SHALL latch addr, we and wdata into internal registers, load the wait counter with WAIT_CYCLES, and enter WAIT; if WAIT_CYCLES=0, enter RESP directly.
REQ-015 WAIT: SHALL decrement the counter each cycle and enter RESP on the edge where the counter is 1.
REQ-016 Latency SHALL be WAIT_CYCLES+1 cycles from the accepting edge to the first cycle with ready=1.
REQ-017 RESP: ready SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE unconditionally.
REQ-018 req, we, addr and wdata SHALL be ignored in WAIT and RESP; only the latched copies are used.
REQ-019 Back-to-back: a req still high in the IDLE cycle following RESP SHALL start a new transaction, giving a minimum period of WAIT_CYCLES+2 cycles.
REQ-020 Word index SHALL be latched addr[DEPTH_LOG2+1:2].
REQ-021 Error condition: latched addr[1:0] != 0, or any latched addr bit above DEPTH_LOG2+1 is 1.
REQ-022 A write without error SHALL update storage on the edge that enters RESP; a write with error SHALL leave storage unchanged.
REQ-023 A read without error SHALL present the stored word on rdata in RESP; with error, rdata SHALL be 0.
REQ-024 err SHALL equal the error condition during RESP and be 0 in all other states.
REQ-025 rdata SHALL be 0 whenever ready=0.
REQ-026 A read to a word written by the immediately preceding transaction SHALL return the new data.

Reset
REQ-027 reset=1 SHALL asynchronously force state IDLE, ready=0, err=0, busy=0, rdata=0, wait counter=0, and latched registers=0.
REQ-028 Reset asserted in WAIT or RESP SHALL abort the transaction; a pending write SHALL NOT be committed.
REQ-029 Storage contents SHALL NOT be cleared by reset, and SHALL be undefined after power-up.
REQ-030 The first clk edge after reset deasserts SHALL be able to accept a request.

Verification
REQ-031 Write/read, WAIT_CYCLES=2: write addr=0x10, wdata=0xDEADBEEF -> ready high 3 cycles after accept with err=0; then read 0x10 -> rdata=0xDEADBEEF, err=0.
REQ-032 Misaligned: write 0x13, wdata=0x1 -> ready with err=1; then read 0x10 -> rdata still 0xDEADBEEF.
REQ-033 Out of range, DEPTH_LOG2=8: read addr=0x400 -> ready with err=1, rdata=0.
REQ-034 Back-to-back with req held high, WAIT_CYCLES=2 -> ready pulses exactly 4 cycles apart; busy low only in the IDLE cycle between transactions.
REQ-035 Reset in WAIT: write 0x20, wdata=0x55 -> assert reset on the next cycle -> ready never rises; after release, read 0x20 returns the prior contents, not 0x55.
REQ-036 WAIT_CYCLES=0: read accepted -> ready high on the very next cycle; busy=1 only in that RESP cycle.
